// File: rtl/als_pkg.sv
// Shared definitions for the Pmod ALS ADC responder.
//   FRAME_W / LEAD_ZEROS / DATA_W / TRAIL_ZEROS : serial frame geometry
//   als_state_e : responder state (IDLE, SHIFT, TAIL)
//   als_frame() : builds the 16-bit frame {3'b000, data, 5'b00000}
package als_pkg;

  localparam int FRAME_W     = 16;
  localparam int LEAD_ZEROS  = 3;
  localparam int DATA_W      = 8;
  localparam int TRAIL_ZEROS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } als_state_e;

  function automatic logic [FRAME_W-1:0] als_frame(input logic [DATA_W-1:0] data);
    return {{LEAD_ZEROS{1'b0}}, data, {TRAIL_ZEROS{1'b0}}};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with edge detection on the synchronized value.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d_i        : asynchronous input
//   rise_o     : one-cycle pulse on a synchronized 0->1 transition
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition
// RST_VAL sets the value the chain assumes during reset so that an input
// already sitting at its idle level does not produce a spurious edge.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RST_VAL}};
      last_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      last_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign rise_o =  chain_q[SYNC_STAGES-1] & ~last_q;
  assign fall_o = ~chain_q[SYNC_STAGES-1] &  last_q;

endmodule

// File: rtl/als_adc_responder.sv
// SPI responder emulating the Pmod ALS ambient-light ADC.
// An 8-bit hold register (written by sample_load) is served MSB first as
// {3'b000, sample, 5'b00000} on sdo while the reader holds cs low and
// toggles sck. Data advances on synchronized sck falling edges.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   cs, sck      : reader chip select (active low) and serial clock, async
//   sample       : value to serve, captured on sample_load
//   sdo          : serial data out
//   busy         : frame in progress (SHIFT or TAIL)
//   frame_done   : one-cycle pulse when a complete frame ends
//   aborted      : sticky, cs rose mid-frame; cleared by sample_load
// Build option: define ALS_SDO_TRISTATE_EN to float sdo while IDLE.
module als_adc_responder
  import als_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sck,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_load,
`ifdef ALS_SDO_TRISTATE_EN
  output wire               sdo,
`else
  output logic              sdo,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              aborted
);

  localparam int                CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);

  logic cs_rise, cs_fall, sck_fall, unused_sck_rise;

  // cs idles high, so its chain resets high to avoid a false frame start.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sck),
    .rise_o (unused_sck_rise),
    .fall_o (sck_fall)
  );

  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  als_state_e         state_q;
  logic               busy_q, frame_done_q, aborted_q;

  assign hold_d = sample_load ? sample : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  // shift_q is kept at zero outside SHIFT, so its MSB is directly the
  // registered sdo value in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (sample_load) aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            // hold_q (not hold_d): a coincident load is served next frame
            shift_q   <= als_frame(hold_q);
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            state_q   <= IDLE;
          end else if (sck_fall) begin
            shift_q   <= {shift_q[FRAME_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) state_q <= TAIL;
          end
        end
        TAIL: begin
          if (cs_rise) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          shift_q <= '0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign aborted    = aborted_q;

`ifdef ALS_SDO_TRISTATE_EN
  logic sdo_oe;
  assign sdo_oe = (state_q != IDLE);
  assign sdo    = sdo_oe ? shift_q[FRAME_W-1] : 1'bz;
`else
  assign sdo = shift_q[FRAME_W-1];
`endif

endmodule

// File: doc/als_adc_responder.md
# als_adc_responder

Clocked SPI responder that emulates the Pmod ALS ambient-light ADC. It lets the sensor reader and the LED display chain run in simulation and on-board without the physical sensor. An 8-bit sample is held locally and served as a 16-bit serial frame on `sdo` whenever the reader asserts `cs` and toggles `sck`. Frame layout is {3'b000, sample[7:0], 5'b00000}, MSB first, which matches what the reader expects.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `cs` and `sck`; legal values are 2 or 3.

Ports:
- `clk`  in  1: system clock; all logic runs on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs`  in  1: chip select from the reader, active low, asynchronous to `clk`.
- `sck`  in  1: serial clock from the reader, asynchronous to `clk`.
- `sample`  in  8: next value to serve.
- `sample_load`  in  1: single-cycle strobe that captures `sample` into the hold register.
- `sdo`  out  1: serial data to the reader.
- `busy`  out  1: high while a frame is in progress.
- `frame_done`  out  1: one-cycle pulse when a complete frame ends.
- `aborted`  out  1: sticky; set when `cs` rises mid-frame; cleared on the next `sample_load`.

## Operation
- The hold register is written on `sample_load` at any time and resets to 8'h00.
- `cs` and `sck` each pass through a `SYNC_STAGES` flop chain; edges are detected on the synchronized values.
- States:
  - IDLE: `sdo`=0, `busy`=0. A synchronized `cs` fall loads shift[15:0] = {3'b000, hold, 5'b00000}, sets bit_cnt=0 and moves to SHIFT.
  - SHIFT: `sdo` = shift[15]. Each synchronized `sck` falling edge shifts left by one, filling with 0, and increments bit_cnt. After the 16th falling edge (bit_cnt wraps 15→0), move to TAIL.
  - TAIL: `sdo`=0. A synchronized `cs` rise pulses `frame_done` and returns to IDLE.
- `cs` rise in SHIFT: set `aborted`, return to IDLE, no `frame_done`.
- A `sample_load` during SHIFT or TAIL updates the hold register only. The frame in flight is unaffected, and the new value is served on the next frame.
- `sample_load` in the same cycle as a detected `cs` fall: the frame uses the old hold value.
- `sck` edges while `cs` is high are ignored.
- Extra `sck` falling edges in TAIL are ignored and `sdo` stays 0.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The frame is lost and `aborted` is not set.

## Timing
- Reset values: `sdo`=0, `busy`=0, `frame_done`=0, `aborted`=0, state IDLE, hold register 8'h00.
- `cs` fall to first bit valid on `sdo`: `SYNC_STAGES`+1 `clk` cycles.
- `sck` fall to next bit on `sdo`: `SYNC_STAGES`+1 `clk` cycles. The reader samples on the `sck` rising edge, so each `sck` half-period must be at least `SYNC_STAGES`+2 `clk` cycles.
- `busy` rises in the same cycle SHIFT is entered and falls in the cycle IDLE is re-entered.
- `frame_done` is asserted for exactly one cycle, coincident with the IDLE transition.
- `cs` setup before the first `sck` fall: at least `SYNC_STAGES`+2 `clk` cycles.

## Configuration
- `ALS_SDO_TRISTATE_EN`:
  - Defined: `sdo` is driven to 1'bz whenever the state is IDLE, matching the real sensor's high-impedance output, and the port is declared `output wire` through an internal enable.
  - Undefined: `sdo` is driven to 0 in IDLE, and all other behaviour is unchanged.

## Structure
- Package `als_pkg` holds:
  - Constants FRAME_W=16, LEAD_ZEROS=3, DATA_W=8, TRAIL_ZEROS=5.
  - State enum {IDLE, SHIFT, TAIL}.
  - Function `als_frame(data)` returning the 16-bit frame.
- Sub-module `sync_edge`: `SYNC_STAGES`-deep synchronizer with rise and fall pulse outputs. It is instantiated once for `cs` and once for `sck`.
- The `clk` period is independent of `sck`. No other sub-modules.

## Test plan
- Load 8'hFF, run a full frame with `sck` half-period of 8 `clk` → captured bits 16'b0001111111100000, `frame_done` pulses once, `aborted`=0.
- Load 8'hA5 → captured 16'b0001010010100000; repeat immediately with 8'h3C → 16'b0000011110000000.
- Load 8'h5A during SHIFT of an 8'hFF frame → current frame reads 8'hFF, next frame reads 8'h5A.
- Raise `cs` after 7 `sck` falls → `aborted`=1, no `frame_done`, `busy`=0 within `SYNC_STAGES`+1 cycles; the next `sample_load` clears `aborted`.
- Assert `rst_n`=0 mid-frame → all outputs at reset values immediately; the following frame reads {3'b0, 8'h00, 5'b0}.
- Toggle `sck` 4 times with `cs` high, then send 20 `sck` falls in one frame → the idle toggles have no effect and bits 17–20 read 0; with `ALS_SDO_TRISTATE_EN`, `sdo`=z while `cs` is high.
